bench_sequencer: RTL and testbench

Synthesizable test-vector sequencer for the jet-tagging inference cores (`waiz_benchmark` and successors). It holds a bank of input vectors and, for each vector, pulses a per-test DUT reset, issues the vector with a one-cycle `input_ready` strobe, and waits for `output_ready` under a timeout. It then streams the captured outputs, measured latency and argmax class out over a valid/ready result port. It replaces simulation-only stimulus loops so on-board latency and accuracy runs use the same sequence as the bench.

---
 rtl/bench_pkg.sv | 13 +
 rtl/argmax_unit.sv | 28 ++
 rtl/bench_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_bench_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bench_pkg.sv
// Shared types for the inference-core test-vector sequencer.
package bench_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DUT_RST,
      S_ISSUE,
      S_WAIT,
      S_EMIT,
      S_DONE
   } bench_state_t;

endpackage

// File: rtl/argmax_unit.sv
// Combinational signed argmax over a packed score vector; equal scores keep the lowest index.
module argmax_unit #(
   parameter int WIDTH       = 16,
   parameter int OUTPUT_SIZE = 5,
   parameter int ARG_W       = $clog2(OUTPUT_SIZE)
) (
   input  logic [OUTPUT_SIZE*WIDTH-1:0] scores,
   output logic [ARG_W-1:0]             argmax
);

   logic signed [WIDTH-1:0] best;
   logic signed [WIDTH-1:0] cand;

   always_comb begin
      best   = $signed(scores[WIDTH-1:0]);
      cand   = '0;
      argmax = '0;
      // strict greater-than so a later equal score never displaces an earlier one
      for (int i = 1; i < OUTPUT_SIZE; i++) begin
         cand = $signed(scores[i*WIDTH +: WIDTH]);
         if (cand > best) begin
            best   = cand;
            argmax = ARG_W'(i);
         end
      end
   end

endmodule

// File: rtl/bench_sequencer.sv
// Test-vector sequencer: replays a bank of input vectors into an inference core, one DUT
// reset per test, and streams captured scores, latency and argmax out per test.
module bench_sequencer
   import bench_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int NFRAC       = 10,
   parameter int INPUT_SIZE  = 16,
   parameter int OUTPUT_SIZE = 5,
   parameter int NUM_TESTS   = 1024,
   parameter int RST_CYCLES  = 2,
   parameter int TIMEOUT     = 4096,
   parameter int IDX_W       = $clog2(NUM_TESTS + 1),
   parameter int LAT_W       = $clog2(TIMEOUT + 1),
   parameter int ELEM_W      = $clog2(INPUT_SIZE),
   parameter int ARG_W       = $clog2(OUTPUT_SIZE)
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          ld_en,
   input  logic [IDX_W-1:0]              ld_test,
   input  logic [ELEM_W-1:0]             ld_elem,
   input  logic signed [WIDTH-1:0]       ld_data,
   input  logic [IDX_W-1:0]              cfg_n_tests,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   output logic                          dut_rst,
   output logic                          dut_input_ready,
   output logic [INPUT_SIZE*WIDTH-1:0]   dut_input_data,
   input  logic                          dut_output_ready,
   input  logic [OUTPUT_SIZE*WIDTH-1:0]  dut_output_data,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [IDX_W-1:0]              res_index,
   output logic [OUTPUT_SIZE*WIDTH-1:0]  res_data,
   output logic [LAT_W-1:0]              res_latency,
   output logic                          res_timeout,
   output logic [ARG_W-1:0]              res_argmax,
   output logic [IDX_W-1:0]              timeout_count
);

   localparam int BANK_AW = $clog2(NUM_TESTS);
   localparam int RC_W    = $clog2(RST_CYCLES + 1);

   if (RST_CYCLES < 1 || NFRAC >= WIDTH) begin : g_param_check
      $error("bench_sequencer: RST_CYCLES must be >= 1 and NFRAC < WIDTH");
   end

   // Result record; field widths follow the module parameters, so the type lives here.
   typedef struct packed {
      logic [IDX_W-1:0]             index;
      logic [OUTPUT_SIZE*WIDTH-1:0] data;
      logic [LAT_W-1:0]             latency;
      logic                         timeout;
      logic [ARG_W-1:0]             argmax;
   } result_t;

   bench_state_t            state_q, state_d;
   logic [IDX_W-1:0]        idx_q;
   logic [IDX_W-1:0]        n_q;
   logic [LAT_W-1:0]        lat_cnt_q;
   logic [RC_W-1:0]         rst_cnt_q;
   logic [IDX_W-1:0]        to_cnt_q;
   result_t                 res_q;
   logic [ARG_W-1:0]        am;
   logic                    wait_expired;
   logic                    last_test;
   logic signed [WIDTH-1:0] bank [NUM_TESTS][INPUT_SIZE];

   argmax_unit #(
      .WIDTH       (WIDTH),
      .OUTPUT_SIZE (OUTPUT_SIZE),
      .ARG_W       (ARG_W)
   ) u_argmax (
      .scores (dut_output_data),
      .argmax (am)
   );

   assign wait_expired = (lat_cnt_q == LAT_W'(TIMEOUT - 1));
   assign last_test    = (idx_q == n_q - IDX_W'(1));

   // Bank is not reset; loads are locked out for the whole run so the issued vector is stable.
   always_ff @(posedge clk) begin
      if (ld_en && !busy && (ld_test < IDX_W'(NUM_TESTS)))
         bank[ld_test[BANK_AW-1:0]][ld_elem] <= ld_data;
   end

   always_comb begin
      dut_input_data = '0;
      for (int i = 0; i < INPUT_SIZE; i++)
         dut_input_data[i*WIDTH +: WIDTH] = bank[idx_q[BANK_AW-1:0]][i];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d         = state_q;
      busy            = 1'b1;
      done            = 1'b0;
      dut_rst         = 1'b0;
      dut_input_ready = 1'b0;
      res_valid       = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            busy    = 1'b0;
            dut_rst = 1'b1;
            done    = (state_q == S_DONE);
            if (start) state_d = (cfg_n_tests == '0) ? S_DONE : S_DUT_RST;
         end
         S_DUT_RST: begin
            dut_rst = 1'b1;
            if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            dut_input_ready = 1'b1;
            state_d         = S_WAIT;
         end
         S_WAIT: begin
            if (dut_output_ready || wait_expired) state_d = S_EMIT;
         end
         S_EMIT: begin
            res_valid = 1'b1;
            if (res_ready) state_d = last_test ? S_DONE : S_DUT_RST;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_q     <= '0;
         n_q       <= '0;
         lat_cnt_q <= '0;
         rst_cnt_q <= '0;
         to_cnt_q  <= '0;
         res_q     <= '0;
      end else begin
         rst_cnt_q <= (state_q == S_DUT_RST) ? rst_cnt_q + RC_W'(1) : '0;
         lat_cnt_q <= (state_q == S_WAIT) ? lat_cnt_q + LAT_W'(1) : '0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start && (cfg_n_tests != '0)) begin
                  idx_q    <= '0;
                  n_q      <= (cfg_n_tests > IDX_W'(NUM_TESTS)) ? IDX_W'(NUM_TESTS) : cfg_n_tests;
                  to_cnt_q <= '0;
               end
            end
            S_WAIT: begin
               // a result arriving on the final allowed cycle wins over the timeout
               if (dut_output_ready) begin
                  res_q.index   <= idx_q;
                  res_q.data    <= dut_output_data;
                  res_q.latency <= lat_cnt_q + LAT_W'(1);
                  res_q.timeout <= 1'b0;
                  res_q.argmax  <= am;
               end else if (wait_expired) begin
                  res_q.index   <= idx_q;
                  res_q.data    <= '0;
                  res_q.latency <= LAT_W'(TIMEOUT);
                  res_q.timeout <= 1'b1;
                  res_q.argmax  <= '0;
                  if (to_cnt_q != '1) to_cnt_q <= to_cnt_q + IDX_W'(1);
               end
            end
            S_EMIT: begin
               if (res_ready && !last_test) idx_q <= idx_q + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign res_index     = res_q.index;
   assign res_data      = res_q.data;
   assign res_latency   = res_q.latency;
   assign res_timeout   = res_q.timeout;
   assign res_argmax    = res_q.argmax;
   assign timeout_count = to_cnt_q;

endmodule

// File: tb/tb_bench_sequencer.sv
// Directed bench for bench_sequencer with a fixed-latency mock inference core.
module tb_bench_sequencer;

   localparam int WIDTH       = 16;
   localparam int INPUT_SIZE  = 16;
   localparam int OUTPUT_SIZE = 5;
   localparam int NUM_TESTS   = 8;
   localparam int RST_CYCLES  = 2;
   localparam int TIMEOUT     = 16;
   localparam int IDX_W       = $clog2(NUM_TESTS + 1);
   localparam int LAT_W       = $clog2(TIMEOUT + 1);
   localparam int ELEM_W      = $clog2(INPUT_SIZE);
   localparam int ARG_W       = $clog2(OUTPUT_SIZE);
   localparam int MOCK_LAT    = 7;
   localparam int V0 [INPUT_SIZE] = '{-304, 378, 253, -8, 123, 14, -399, -144,
                                      -399, -629, -664, -537, -586, -376, 284, 430};

   logic                          clk = 1'b0;
   logic                          reset_n = 1'b0;
   logic                          ld_en = 1'b0;
   logic [IDX_W-1:0]              ld_test = '0;
   logic [ELEM_W-1:0]             ld_elem = '0;
   logic signed [WIDTH-1:0]       ld_data = '0;
   logic [IDX_W-1:0]              cfg_n_tests = '0;
   logic                          start = 1'b0;
   logic                          busy, done, dut_rst, dut_input_ready;
   logic [INPUT_SIZE*WIDTH-1:0]   dut_input_data;
   logic                          dut_output_ready;
   logic [OUTPUT_SIZE*WIDTH-1:0]  dut_output_data;
   logic                          res_valid;
   logic                          res_ready = 1'b0;
   logic [IDX_W-1:0]              res_index;
   logic [OUTPUT_SIZE*WIDTH-1:0]  res_data;
   logic [LAT_W-1:0]              res_latency;
   logic                          res_timeout;
   logic [ARG_W-1:0]              res_argmax;
   logic [IDX_W-1:0]              timeout_count;

   logic                          mock_en = 1'b0;
   logic [OUTPUT_SIZE*WIDTH-1:0]  mock_out = '0;
   logic                          mock_active = 1'b0;
   int                            mock_cnt = 0;
   int                            issue_cnt = 0;
   int                            n_cmp = 0;
   int                            n_fail = 0;

   bench_sequencer #(
      .WIDTH (WIDTH), .NFRAC (10), .INPUT_SIZE (INPUT_SIZE), .OUTPUT_SIZE (OUTPUT_SIZE),
      .NUM_TESTS (NUM_TESTS), .RST_CYCLES (RST_CYCLES), .TIMEOUT (TIMEOUT)
   ) dut (
      .clk (clk), .reset_n (reset_n), .ld_en (ld_en), .ld_test (ld_test), .ld_elem (ld_elem),
      .ld_data (ld_data), .cfg_n_tests (cfg_n_tests), .start (start), .busy (busy), .done (done),
      .dut_rst (dut_rst), .dut_input_ready (dut_input_ready), .dut_input_data (dut_input_data),
      .dut_output_ready (dut_output_ready), .dut_output_data (dut_output_data),
      .res_valid (res_valid), .res_ready (res_ready), .res_index (res_index), .res_data (res_data),
      .res_latency (res_latency), .res_timeout (res_timeout), .res_argmax (res_argmax),
      .timeout_count (timeout_count)
   );

   always #5 clk = ~clk;

   // Mock core: result valid MOCK_LAT cycles after the issue cycle, held until its reset.
   always @(posedge clk) begin
      if (dut_rst) begin
         mock_active <= 1'b0;
         mock_cnt    <= 0;
      end else if (dut_input_ready) begin
         mock_active <= 1'b1;
         mock_cnt    <= 1;
      end else if (mock_active) begin
         mock_cnt    <= mock_cnt + 1;
      end
      if (dut_input_ready) issue_cnt <= issue_cnt + 1;
   end

   assign dut_output_ready = mock_en && mock_active && (mock_cnt >= MOCK_LAT);
   assign dut_output_data  = mock_out;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] vec_exp(input int t);
      logic [255:0] v = '0;
      for (int e = 0; e < INPUT_SIZE; e++)
         v[e*WIDTH +: WIDTH] = (t == 0) ? 16'(V0[e]) : 16'(t * 256 + e * 3 - 40);
      return v;
   endfunction

   function automatic logic [79:0] pack5(input int a, input int b, input int c, input int d,
                                         input int e);
      return {16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   task automatic pulse_start(input int n);
      cfg_n_tests = IDX_W'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_issue();
      int n = 0;
      while (dut_input_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("issue_wait", dut_input_ready, 1);
   endtask

   task automatic get_result(input int idx, input int lat, input logic to,
                             input logic [79:0] data, input int arg, input int stall);
      int n = 0;
      while (res_valid !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check("res_valid_wait", res_valid, 1);
      check("res_index", res_index, idx);
      check("res_latency", res_latency, lat);
      check("res_timeout", res_timeout, to);
      check("res_data", res_data, data);
      check("res_argmax", res_argmax, arg);
      for (int s = 0; s < stall; s++) begin
         tick();
         check("stall_valid", res_valid, 1);
         check("stall_index", res_index, idx);
         check("stall_latency", res_latency, lat);
         check("stall_data", res_data, data);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] vtmp;
      logic [79:0]  sc;
      int nres;
      int last_idx;
      int n;

      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_dut_rst", dut_rst, 1);
      check("rst_input_ready", dut_input_ready, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_fields", {res_index, res_latency, res_timeout, res_argmax}, 0);
      check("rst_res_data", res_data, 0);
      check("rst_timeout_count", timeout_count, 0);
      reset_n = 1'b1;
      tick();

      for (int t = 0; t < NUM_TESTS; t++) begin
         vtmp = vec_exp(t);
         for (int e = 0; e < INPUT_SIZE; e++) begin
            ld_en   = 1'b1;
            ld_test = IDX_W'(t);
            ld_elem = ELEM_W'(e);
            ld_data = vtmp[e*WIDTH +: WIDTH];
            tick();
         end
      end
      ld_en = 1'b0;
      tick();
      check("idle_vector0", dut_input_data, vec_exp(0));

      // zero tests: straight to done, no DUT activity
      pulse_start(0);
      check("cfg0_done", done, 1);
      check("cfg0_busy", busy, 0);
      tick();
      check("cfg0_no_issue", issue_cnt, 0);

      // single test, latency 7, tie between words 1 and 2
      mock_en  = 1'b1;
      sc       = pack5(10, 300, 300, -5, 0);
      mock_out = sc;
      pulse_start(1);
      check("t1_busy", busy, 1);
      check("t1_rst_c1", dut_rst, 1);
      tick();
      check("t1_rst_c2", {dut_rst, dut_input_ready}, 2'b10);
      tick();
      check("t1_issue", {dut_rst, dut_input_ready}, 2'b01);
      check("t1_vector", dut_input_data, vec_exp(0));
      n = 0;
      while (res_valid !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("t1_issue_to_valid", n, MOCK_LAT + 1);
      get_result(0, MOCK_LAT, 1'b0, sc, 1, 0);
      check("t1_done", {done, busy}, 2'b10);
      check("t1_issue_cnt", issue_cnt, 1);

      // all scores equal and negative
      sc       = pack5(-1, -1, -1, -1, -1);
      mock_out = sc;
      pulse_start(1);
      get_result(0, MOCK_LAT, 1'b0, sc, 0, 0);
      check("t2_done", done, 1);

      // silent core: every test times out
      mock_en = 1'b0;
      pulse_start(3);
      for (int i = 0; i < 3; i++) get_result(i, TIMEOUT, 1'b1, '0, 0, 0);
      check("t3_done", done, 1);
      check("t3_timeout_count", timeout_count, 3);

      // back-pressure: five stalled cycles on every result
      mock_en  = 1'b1;
      sc       = pack5(-100, 50, -7, 49, 51);
      mock_out = sc;
      pulse_start(4);
      check("t4_timeout_count_clr", timeout_count, 0);
      for (int i = 0; i < 4; i++) begin
         wait_issue();
         check("t4_vector", dut_input_data, vec_exp(i));
         get_result(i, MOCK_LAT, 1'b0, sc, 4, 5);
      end
      check("t4_done", done, 1);
      check("t4_issue_cnt", issue_cnt, 9);

      // request beyond the bank depth is clamped
      res_ready = 1'b1;
      pulse_start(NUM_TESTS + 5);
      nres = 0;
      last_idx = -1;
      n = 0;
      while (done !== 1'b1 && n < 500) begin
         if (res_valid === 1'b1) begin
            nres++;
            last_idx = int'(res_index);
         end
         tick();
         n++;
      end
      check("t5_done", done, 1);
      check("t5_result_count", nres, NUM_TESTS);
      check("t5_last_index", last_idx, NUM_TESTS - 1);

      // write attempt while busy, then reset during the wait of test 2
      pulse_start(4);
      ld_en   = 1'b1;
      ld_test = '0;
      ld_elem = '0;
      ld_data = 16'sh7777;
      tick();
      ld_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wait_issue();
         if (k < 2) tick();
      end
      tick();
      tick();
      check("t6_in_wait", {busy, res_valid}, 2'b10);
      #2 reset_n = 1'b0;
      #1;
      check("t6_rst_busy", busy, 0);
      check("t6_rst_dut_rst", dut_rst, 1);
      check("t6_rst_res_valid", res_valid, 0);
      check("t6_rst_res_fields", {res_index, res_latency, res_timeout, res_argmax}, 0);
      check("t6_rst_res_data", res_data, 0);
      check("t6_rst_done", done, 0);
      check("t6_bank_kept", dut_input_data, vec_exp(0));
      res_ready = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      pulse_start(1);
      wait_issue();
      check("t6_rerun_vector", dut_input_data, vec_exp(0));
      get_result(0, MOCK_LAT, 1'b0, sc, 4, 0);
      check("t6_rerun_done", done, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
